// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
//   - funct3 encodings of the eight M-extension ops
//   - sequencer state enum (also exported on the debug port)
//   - opcode/funct7 constants decode uses to steer M-ops to this unit
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // True for an instruction that decode should hand to the sequencer.
  function automatic logic is_mop(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPC_RTYPE) && (funct7 == F7_MULDIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration, purely combinational.
//   is_div    : 0 = shift-add multiply step, 1 = restoring-divide step
//   acc       : 2*XLEN working register
//               multiply: {partial product high, multiplier / product low}
//               divide  : {remainder, dividend being shifted out / quotient}
//   opnd      : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   acc_next  : acc after this step (divide: quotient LSB left as 0)
//   qbit      : quotient bit produced by the trial subtraction
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_next,
  output logic              qbit
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  always_comb begin
    sum   = '0;
    trial = '0;
    diff  = '0;
    qbit  = 1'b0;
    acc_next = '0;
    // Multiply: add multiplicand into the high half when the multiplier LSB
    // is set, then shift the whole register right; carry enters the top.
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: shift the next dividend bit into the remainder and try to
    // subtract. A clear top bit of the XLEN+1 difference means it fit.
    trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff  = trial - {1'b0, opnd};
    qbit  = ~diff[XLEN];
    if (is_div) begin
      acc_next = {(qbit ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
// Operands are converted to magnitudes on accept, iterated XLEN times in
// muldiv_step, and the sign is restored in FIX.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start_i        request, only sampled in IDLE
//   op_i           funct3 of the M-op
//   a_i, b_i       rs1 / rs2 operands, captured with start_i
//   kill_i         flush: abort and return to IDLE at the next edge
//   busy_o         high in every state but IDLE
//   done_o         one-cycle pulse, result_o valid in that cycle
//   result_o       result, held until the next done_o
//   dbg_state      current FSM state
// Handshake: a request is accepted at a rising edge where the unit is in
// IDLE, start_i=1 and kill_i=0; busy_o rises in the following cycle. Each
// accepted request produces exactly one done_o unless killed or reset.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output state_t          dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_next;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd;
  logic              res_neg;

  // Accept-time decode
  logic              signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [2*XLEN-1:0] init_acc;
  logic [XLEN-1:0]   init_opnd;
  logic              init_neg;
  logic              accept;

  // Iteration and fix-up
  logic [2*XLEN-1:0] step_acc;
  logic              step_qbit;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_word;
  logic [XLEN-1:0]   fix_word;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (op_q[2]),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (step_acc),
    .qbit     (step_qbit)
  );

  always_comb begin
    signed_a  = (op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM);
    signed_b  = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg     = signed_a & a_i[XLEN-1];
    b_neg     = signed_b & b_i[XLEN-1];
    a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag     = b_neg ? (~b_i + 1'b1) : b_i;
    div_zero  = op_i[2] && (b_i == '0);
    div_ovf   = ((op_i == OP_DIV) || (op_i == OP_REM)) && (a_i == MIN_NEG) && (b_i == '1);
    special   = div_zero || div_ovf;
    accept    = start_i && !kill_i;

    // Special cases preload {remainder, quotient} with the final answer so
    // FIX selects it exactly like a computed result.
    init_opnd = b_mag;
    if (div_zero) begin
      init_acc = {a_i, {XLEN{1'b1}}};
      init_neg = 1'b0;
    end else if (div_ovf) begin
      init_acc = {{XLEN{1'b0}}, MIN_NEG};
      init_neg = 1'b0;
    end else begin
      init_acc = {{XLEN{1'b0}}, a_mag};
      // Remainder follows the dividend; everything else is a XOR b.
      init_neg = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
    end
  end

  // Result selection: the product is negated as a full 2*XLEN word so the
  // high half picks up the borrow from the low half.
  always_comb begin
    prod     = res_neg ? (~acc + 1'b1) : acc;
    div_word = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (!op_q[2]) begin
      fix_word = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else begin
      fix_word = res_neg ? (~div_word + 1'b1) : div_word;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = special ? S_FIX : S_CALC;
      S_CALC: begin
        if (kill_i)                        state_next = S_IDLE;
        else if (count == CW'(XLEN - 1))   state_next = S_FIX;
      end
      S_FIX:  state_next = kill_i ? S_IDLE : S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      count    <= '0;
      op_q     <= '0;
      acc      <= '0;
      opnd     <= '0;
      res_neg  <= 1'b0;
      result_o <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q    <= op_i;
            acc     <= init_acc;
            opnd    <= init_opnd;
            res_neg <= init_neg;
            count   <= '0;
          end
        end
        S_CALC: begin
          acc   <= {step_acc[2*XLEN-1:1], (op_q[2] ? step_qbit : step_acc[0])};
          // Cleared on the last step so the counter never wraps.
          count <= (count == CW'(XLEN - 1)) ? '0 : count + 1'b1;
        end
        S_FIX: begin
          if (!kill_i) result_o <= fix_word;
        end
        default: ;
      endcase
    end
  end

  assign busy_o    = (state != S_IDLE);
  assign done_o    = (state == S_DONE);
  assign dbg_state = state;

endmodule
